pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into SEG-bit lookahead segments and resolves one segment per clock, registering the segment carry between stages. It supports add and subtract modes and moves operands and results over valid/ready handshakes. It sits in the convolution datapath as the wide accumulator adder, where a single-cycle ripple through all segments does not close timing.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, bits resolved per pipeline stage (one lookahead segment).
- STAGES, WIDTH/SEG (derived localparam, not overridable), pipeline depth.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  stage 0 can accept; combinational.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed (two's-complement) overflow.
- op_count  output  32  completed-operation counter (see Configuration).

## Operation
- Effective operation:
  - add: sum = a + b + cin.
  - sub: sum = a + ~b + 1. cin is ignored.
  - All arithmetic is modulo 2^WIDTH. cout is bit WIDTH of the full sum.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] with SEG-bit generate/propagate lookahead. Its carry-in is:
  - the effective carry-in for k = 0;
  - the carry registered by stage k-1 otherwise.
- Each stage register holds:
  - valid bit;
  - already-resolved low sum bits;
  - unresolved high a and effective-b bits;
  - segment carry-out;
  - sign bits of a and effective-b, needed for ovf.
- ovf = (sa == sb_eff) && (sum[WIDTH-1] != sa), evaluated in the final stage.
- Stage k advances when its register is empty or stage k+1 advances. The last stage advances on out_ready.
- in_ready = !valid[0] || advance[0]. The ready chain is combinational from out_ready, so there are no bubbles under continuous flow.
- out_valid = valid[STAGES-1]. sum, cout and ovf come directly from the last stage register and are held stable while out_valid && !out_ready.
- A transfer occurs only when valid && ready on the same edge. a, b, cin and sub are sampled only on the input transfer.

## Timing
- Latency: a beat accepted at edge t presents out_valid after edge t+STAGES-1, so it appears STAGES cycles after acceptance.
- Throughput: one operation per cycle when out_ready is held high.
- Reset (rst high at an edge):
  - all valid bits clear, so out_valid = 0;
  - sum = 0, cout = 0, ovf = 0, op_count = 0;
  - in_ready = 0 while rst is high.
- Reset mid-operation discards all in-flight beats; none are output afterwards.
- Full pipeline with out_ready low:
  - in_ready = 0;
  - no register changes;
  - pending in_valid is held off.
- Simultaneous accept and release: with a full pipeline and out_ready high, the new input is accepted on the same edge the oldest result leaves.
- STAGES = 1 (SEG = WIDTH): degenerates to a one-register adder with latency 1.

## Configuration
- PIPELINED_CLA_OPCOUNT_EN defined:
  - op_count increments by 1 on every output transfer (out_valid && out_ready);
  - saturates at 32'hFFFF_FFFF;
  - clears on rst.
- Not defined: op_count is constant 0 and no counter register is built. The port is always present.

## Test plan
- WIDTH=32, SEG=8, out_ready=1. Add a=32'h0000_00FF, b=32'h0000_0001, cin=0 -> 4 cycles after acceptance: sum=32'h0000_0100, cout=0, ovf=0.
- Full carry ripple across all segments: a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
- Subtract and signed overflow:
  - sub=1, a=5, b=7 -> sum=32'hFFFF_FFFE, cout=0, ovf=0.
  - sub=0, a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, ovf=1.
- Backpressure:
  - stream 6 beats, drop out_ready after the first output -> pipeline fills, in_ready=0 after 4 held beats, sum stable;
  - release out_ready -> results arrive in order with no loss or duplication.
- Reset mid-flight: assert rst one cycle with 3 beats in flight -> out_valid=0 next cycle, none of the 3 beats ever emitted, op_count=0.
- With PIPELINED_CLA_OPCOUNT_EN: 10 completed transfers -> op_count=10. Without the macro: op_count=0 throughout.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
// into SEG-bit lookahead segments; stage k resolves segment k and registers
// its carry for stage k+1, so one segment's lookahead is the only carry path
// per clock. WIDTH must be a multiple of SEG.
//
// Handshake (both ports): a beat transfers on a rising edge only when valid
// and ready are both high. A producer holds valid and data until the
// transfer. The ready chain is combinational from out_ready back to in_ready,
// so a full pipeline accepts a new beat on the same edge the oldest result
// leaves. Operand inputs are sampled only on the input transfer.
//
// Optional feature: define PIPELINED_CLA_OPCOUNT_EN to build a saturating
// counter of completed output transfers on op_count; otherwise op_count is 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready operand handshake (in_ready is 0 while rst is high)
//   a, b, cin, sub      operands, carry-in (add only), 0=add 1=subtract
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry out of bit WIDTH-1, signed overflow
//   op_count            completed-operation counter
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [31:0]      op_count
);

  localparam int STAGES = WIDTH / SEG;

  // One SEG-bit lookahead segment: returns {carry_out, sum_bits}.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  // Subtract is a + ~b + 1, so the operand inversion and forced carry-in
  // happen once at the input and the stages only ever add.
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;
  logic              accept;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  assign in_ready = !rst && adv[0];
  assign accept   = in_valid && in_ready;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : stg
    localparam int LO = (k + 1) * SEG;  // sum bits resolved after this stage
    localparam int HI = WIDTH - LO;     // operand bits still to be added

    logic           v_q;
    logic           c_q;
    logic           sa_q;
    logic           sb_q;
    logic [LO-1:0]  s_q;

    logic           src_v;
    logic           src_ci;
    logic           src_sa;
    logic           src_sb;
    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic [SEG:0]   seg_r;
    logic [LO-1:0]  s_nxt;

    if (k == 0) begin : g_src
      assign src_v  = accept;
      assign src_ci = c_eff;
      assign src_sa = a[WIDTH-1];
      assign src_sb = b_eff[WIDTH-1];
      assign seg_a  = a[SEG-1:0];
      assign seg_b  = b_eff[SEG-1:0];
      assign s_nxt  = seg_r[SEG-1:0];
    end else begin : g_src
      assign src_v  = stg[k-1].v_q;
      assign src_ci = stg[k-1].c_q;
      assign src_sa = stg[k-1].sa_q;
      assign src_sb = stg[k-1].sb_q;
      assign seg_a  = stg[k-1].hi.a_q[SEG-1:0];
      assign seg_b  = stg[k-1].hi.b_q[SEG-1:0];
      assign s_nxt  = {seg_r[SEG-1:0], stg[k-1].s_q};
    end

    assign seg_r  = cla_seg(seg_a, seg_b, src_ci);
    assign vld[k] = v_q;

    // Payload only loads with a valid beat, so a stalled or idle stage
    // keeps its last contents.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        sa_q <= 1'b0;
        sb_q <= 1'b0;
        s_q  <= '0;
      end else if (adv[k]) begin
        v_q <= src_v;
        if (src_v) begin
          s_q  <= s_nxt;
          c_q  <= seg_r[SEG];
          sa_q <= src_sa;
          sb_q <= src_sb;
        end
      end
    end

    if (HI > 0) begin : hi
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;
      logic [HI-1:0] a_nxt;
      logic [HI-1:0] b_nxt;

      if (k == 0) begin : g_hsrc
        assign a_nxt = a[WIDTH-1:SEG];
        assign b_nxt = b_eff[WIDTH-1:SEG];
      end else begin : g_hsrc
        assign a_nxt = stg[k-1].hi.a_q[HI+SEG-1:SEG];
        assign b_nxt = stg[k-1].hi.b_q[HI+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && src_v) begin
          a_q <= a_nxt;
          b_q <= b_nxt;
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = stg[STAGES-1].s_q;
  assign cout      = stg[STAGES-1].c_q;
  // Signed overflow: operands of equal sign produced a result of the other sign.
  assign ovf       = (stg[STAGES-1].sa_q == stg[STAGES-1].sb_q) &&
                     (stg[STAGES-1].s_q[WIDTH-1] != stg[STAGES-1].sa_q);

`ifdef PIPELINED_CLA_OPCOUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

endmodule
